if_prefetch_stage: RTL and testbench
====================================

// Module: if_prefetch_stage
// PURPOSE
//  Parametrised instruction-fetch stage with a decoupled prefetch queue, replacing the single-PC fetch.
//  Issues in-order requests to a handshaked instruction memory and buffers returned words in a FIFO.
//  Presents instructions to ID over valid/ready, so a freeze stalls only the output, not fetch.
//  On a taken branch: flushes the queue, redirects the PC, and discards in-flight responses.
// PARAMETERS
//  ADDR_W    32  PC / memory byte-address width
//  INST_W    32  instruction width
//  DEPTH     4   prefetch FIFO entries (power of 2, >=2); also caps queued + in-flight words
//  MAX_OUT   2   max requests accepted but not yet answered (<=DEPTH)
//  RESET_PC  0   byte address fetched first after reset
//  PC_STEP   4   byte increment per instruction
// PORTS
//  clk           in   1       clock, rising edge
//  rst           in   1       asynchronous, active-low reset
//  branch_taken  in   1       redirect pulse from EX, one cycle
//  branch_addr   in   ADDR_W  redirect target, byte address
//  out_ready     in   1       ID can accept (driven as ~freeze)
//  out_valid     out  1       out_inst/out_pc valid
//  out_inst      out  INST_W  instruction at queue head
//  out_pc        out  ADDR_W  byte address of out_inst
//  out_pc_next   out  ADDR_W  out_pc + PC_STEP
//  imem_req      out  1       fetch request
//  imem_addr     out  ADDR_W  fetch byte address, low 2 bits always 0
//  imem_gnt      in   1       request accepted this cycle
//  imem_rvalid   in   1       response valid; in order, >=1 cycle after grant
//  imem_rdata    in   INST_W  response data
//  proto_err     out  1       sticky: rvalid seen with nothing in flight
// BEHAVIOUR
//  Reset (rst=0, async):
//   - fetch_pc=RESET_PC, head_pc=RESET_PC.
//   - FIFO empty, outstanding=0, drop_cnt=0.
//   - out_valid=0, imem_req=0, proto_err=0.
//  Issue:
//   - imem_req = !branch_taken && (outstanding < MAX_OUT) && (fifo_count + outstanding + drop_cnt*0 < DEPTH).
//   - Credit rule: discarded responses need no FIFO slot.
//   - imem_addr = fetch_pc.
//   - On imem_req && imem_gnt: fetch_pc += PC_STEP (mod 2^ADDR_W, wraps silently); outstanding += 1.
//  Response:
//   - On imem_rvalid: outstanding -= 1.
//   - If drop_cnt > 0: drop_cnt -= 1 and the word is discarded.
//   - Otherwise the word is pushed into the FIFO.
//   - Pushed words are visible at the output the next cycle (no bypass).
//   - Min latency with 1-cycle memory: req at t, rvalid at t+1, out_valid at t+2.
//  Output:
//   - out_valid = FIFO non-empty; out_inst = head entry; out_pc = head_pc.
//   - Pop on out_valid && out_ready; head_pc += PC_STEP.
//   - Push and pop in the same cycle are legal, including at count=DEPTH-1 or full.
//   - The credit rule guarantees no overflow.
//   - Outputs hold stable while out_valid && !out_ready.
//  Branch (branch_taken=1), at the clock edge:
//   - FIFO cleared; head_pc = fetch_pc = {branch_addr[ADDR_W-1:2], 2'b00}.
//   - drop_cnt = outstanding after this cycle's rvalid decrement.
//   - An rvalid in the branch cycle is itself discarded.
//   - No request is issued in the branch cycle.
//   - A pop in the branch cycle completes normally; ID owns squashing it.
//   - A branch while drop_cnt > 0 recomputes drop_cnt from the current outstanding.
//  proto_err:
//   - Set on imem_rvalid with outstanding==0; the word is ignored.
//   - Cleared only by reset.
//  Reset mid-operation:
//   - Immediate return to the reset state.
//   - The memory must drop in-flight responses on the same reset.
// TESTING
//  1 Reset, 1-cycle mem, out_ready=1 -> imem_addr 0,4,8...; out_pc 0,4,8... from cycle 2; out_pc_next = out_pc+4.
//  2 out_ready=0 for 10 cycles -> exactly DEPTH=4 words queued, imem_req=0; release -> pc 0,4,8,12 in 4 cycles, no gaps or duplicates.
//  3 2 in flight, branch_taken with branch_addr=0x103 -> both responses dropped; next out_pc=0x100, imem_addr 0x100.
//  4 rvalid coincident with branch, 1 other in flight -> drop_cnt=1; only data fetched from target reaches the output.
//  5 Full FIFO with simultaneous pop+push for 20 cycles -> no loss or overflow; out_pc strictly +4 per pop.
//  6 imem_gnt held 0 -> fetch_pc frozen, imem_req stays 1; spurious rvalid -> proto_err=1 until rst=0.

Source files
------------

// File: rtl/if_prefetch_stage.sv
// Instruction-fetch stage with a decoupled prefetch queue.
// Requests are issued in order to a handshaked instruction memory, returned
// words are buffered in a small FIFO, and ID consumes them over valid/ready.
// A taken branch flushes the queue, redirects fetch and discards responses
// that are still in flight.
module if_prefetch_stage #(
  parameter int                ADDR_W   = 32,
  parameter int                INST_W   = 32,
  parameter int                DEPTH    = 4,
  parameter int                MAX_OUT  = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                PC_STEP  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_addr,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [INST_W-1:0] out_inst,
  output logic [ADDR_W-1:0] out_pc,
  output logic [ADDR_W-1:0] out_pc_next,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [INST_W-1:0] imem_rdata,
  output logic              proto_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [ADDR_W-1:0] STEP     = ADDR_W'(PC_STEP);
  localparam logic [ADDR_W-1:0] ALIGN_MK = ~ADDR_W'(3);

  logic [INST_W-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  outstanding_q, outstanding_d;
  logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] head_pc_q, head_pc_d;
  logic              proto_err_q, proto_err_d;

  logic              req_hs;
  logic              rsp_ok;
  logic              push;
  logic              pop;
  logic [CNT_W:0]    credit_used;
  logic [CNT_W-1:0]  out_after_rsp;
  logic [ADDR_W-1:0] branch_tgt;

  // Issue, response accounting and output handshake decisions.
  always_comb begin
    credit_used = {1'b0, count_q} + {1'b0, outstanding_q};
    // Gating with rst keeps the request low while reset is held.
    imem_req    = rst && !branch_taken
                  && (outstanding_q < CNT_W'(MAX_OUT))
                  && (credit_used < (CNT_W + 1)'(DEPTH));
    req_hs      = imem_req && imem_gnt;
    // A response with nothing in flight is a protocol error and is ignored.
    rsp_ok      = imem_rvalid && (outstanding_q != '0);
    push        = rsp_ok && !branch_taken && (drop_cnt_q == '0);
    out_valid   = (count_q != '0);
    pop         = out_valid && out_ready;
    out_after_rsp = outstanding_q - CNT_W'(rsp_ok);
    branch_tgt  = branch_addr & ALIGN_MK;
  end

  // Next-state computation for queue pointers, counters and PCs.
  always_comb begin
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;
    outstanding_d = out_after_rsp + CNT_W'(req_hs);
    drop_cnt_d    = drop_cnt_q;
    fetch_pc_d    = fetch_pc_q;
    head_pc_d     = head_pc_q;
    proto_err_d   = proto_err_q || (imem_rvalid && (outstanding_q == '0));

    if (branch_taken) begin
      // Everything still in flight after this cycle belongs to the old path.
      count_d    = '0;
      rd_ptr_d   = wr_ptr_q;
      drop_cnt_d = out_after_rsp;
      fetch_pc_d = branch_tgt;
      head_pc_d  = branch_tgt;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
      if (rsp_ok && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - CNT_W'(1);
      if (req_hs) fetch_pc_d = fetch_pc_q + STEP;
      if (pop)    head_pc_d  = head_pc_q + STEP;
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      fetch_pc_q    <= RESET_PC;
      head_pc_q     <= RESET_PC;
      proto_err_q   <= 1'b0;
    end else begin
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      fetch_pc_q    <= fetch_pc_d;
      head_pc_q     <= head_pc_d;
      proto_err_q   <= proto_err_d;
    end
  end

  // Prefetch storage; contents are qualified by count, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= imem_rdata;
  end

  // Output views of the queue head and fetch pointer.
  always_comb begin
    out_inst    = mem_q[rd_ptr_q];
    out_pc      = head_pc_q;
    out_pc_next = head_pc_q + STEP;
    imem_addr   = fetch_pc_q & ALIGN_MK;
    proto_err   = proto_err_q;
  end

endmodule

// File: tb/tb_if_prefetch_stage.sv
// Bench for if_prefetch_stage: behavioural instruction memory with a
// configurable latency, a scoreboard of expected PCs, and a monitor that
// checks every accepted instruction against the scoreboard head.
module tb_if_prefetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_addr = 32'h0;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic [31:0] out_pc_next;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        proto_err;

  if_prefetch_stage dut (
    .clk(clk), .rst(rst),
    .branch_taken(branch_taken), .branch_addr(branch_addr),
    .out_ready(out_ready), .out_valid(out_valid), .out_inst(out_inst),
    .out_pc(out_pc), .out_pc_next(out_pc_next),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] exp_q[$];

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;
  pend_t pend[$];

  int          mem_lat   = 1;
  bit          spurious  = 1'b0;
  int          cyc       = 0;
  int          hs_cnt    = 0;
  logic [31:0] mdl_fetch = 32'h0;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // Instruction memory: in-order responses mem_lat cycles after grant,
  // plus a model of the fetch PC used to check each granted address.
  initial begin : memory
    pend_t p;
    forever begin
      @(negedge clk); #2;
      cyc++;
      if (!rst) begin
        pend.delete();
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        mdl_fetch   = 32'h0;
        hs_cnt      = 0;
      end else begin
        if (spurious) begin
          imem_rvalid = 1'b1;
          imem_rdata  = 32'hDEAD_BEEF;
        end else if (pend.size() != 0 && pend[0].due <= cyc) begin
          p = pend.pop_front();
          imem_rvalid = 1'b1;
          imem_rdata  = word_of(p.addr);
        end else begin
          imem_rvalid = 1'b0;
          imem_rdata  = 32'h0;
        end
        if (branch_taken) begin
          chk("req_in_branch_cycle", 32'(imem_req), 32'd0);
          mdl_fetch = branch_addr & 32'hFFFF_FFFC;
        end else if (imem_req && imem_gnt) begin
          chk("imem_addr", imem_addr, mdl_fetch);
          p.addr = mdl_fetch;
          p.due  = cyc + mem_lat;
          pend.push_back(p);
          mdl_fetch = mdl_fetch + 32'd4;
          hs_cnt++;
        end
      end
    end
  end

  // Monitor: every accepted instruction must match the scoreboard head.
  initial begin : monitor
    logic [31:0] e;
    forever begin
      @(negedge clk); #4;
      if (rst && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_pop: got out_pc 0x%08h, expected no output", out_pc);
        end else begin
          e = exp_q.pop_front();
          chk("out_pc", out_pc, e);
          chk("out_inst", out_inst, word_of(e));
          chk("out_pc_next", out_pc_next, e + 32'd4);
        end
      end
    end
  end

  task automatic push_exp(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(base + 32'(4 * i));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst          = 1'b0;
    branch_taken = 1'b0;
    out_ready    = 1'b0;
    imem_gnt     = 1'b0;
    spurious     = 1'b0;
    exp_q.delete();
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_imem_req", 32'(imem_req), 32'd0);
    chk("rst_proto_err", 32'(proto_err), 32'd0);
    chk("rst_imem_addr", imem_addr, 32'h0);
    chk("rst_out_pc", out_pc, 32'h0);
    @(negedge clk);
  endtask

  task automatic wait_drain(input int max_cyc);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    out_ready = 1'b0;
    chk("drain_remaining", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  // Fetch two words, branch in cycle 3, expect only target-path data.
  task automatic branch_test(input int lat, input logic [31:0] target);
    do_reset();
    mem_lat  = lat;
    imem_gnt = 1'b1;
    rst      = 1'b1;
    @(negedge clk);
    @(negedge clk);
    branch_taken = 1'b1;
    branch_addr  = target;
    @(negedge clk);
    branch_taken = 1'b0;
    push_exp(target & 32'hFFFF_FFFC, 4);
    out_ready = 1'b1;
    #1;
    chk("branch_imem_addr", imem_addr, target & 32'hFFFF_FFFC);
    chk("branch_out_valid", 32'(out_valid), 32'd0);
    wait_drain(40);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    // 1: streaming with a 1-cycle memory.
    do_reset();
    mem_lat = 1;
    imem_gnt = 1'b1;
    out_ready = 1'b1;
    push_exp(32'h0, 10);
    rst = 1'b1;
    @(negedge clk); #1;
    chk("lat_cycle2_valid", 32'(out_valid), 32'd0);
    @(negedge clk); #1;
    chk("lat_cycle3_valid", 32'(out_valid), 32'd1);
    chk("lat_first_pc", out_pc, 32'h0);
    wait_drain(40);

    // 2: frozen output fills exactly DEPTH entries.
    do_reset();
    mem_lat = 1;
    imem_gnt = 1'b1;
    rst = 1'b1;
    repeat (10) @(negedge clk);
    #1;
    chk("freeze_grants", 32'(hs_cnt), 32'd4);
    chk("freeze_imem_req", 32'(imem_req), 32'd0);
    chk("freeze_out_valid", 32'(out_valid), 32'd1);
    chk("freeze_out_pc", out_pc, 32'h0);
    push_exp(32'h0, 8);
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    chk("release_valid", 32'(out_valid), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk("release_valid", 32'(out_valid), 32'd1);
    end
    wait_drain(60);

    // 3: two in flight, branch to unaligned 0x103.
    branch_test(3, 32'h0000_0103);

    // 4: response coincident with the branch, one other in flight.
    branch_test(2, 32'h0000_0200);

    // 5: full queue drained while refilling.
    do_reset();
    mem_lat = 1;
    imem_gnt = 1'b1;
    rst = 1'b1;
    repeat (8) @(negedge clk);
    push_exp(32'h0, 28);
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      chk("stream_valid", 32'(out_valid), 32'd1);
    end
    wait_drain(60);

    // 6: grant withheld, then a spurious response.
    do_reset();
    mem_lat = 1;
    imem_gnt = 1'b0;
    out_ready = 1'b1;
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      chk("nogrant_req", 32'(imem_req), 32'd1);
      chk("nogrant_addr", imem_addr, 32'h0);
    end
    @(negedge clk);
    spurious = 1'b1;
    @(negedge clk);
    spurious = 1'b0;
    #1;
    chk("proto_err_set", 32'(proto_err), 32'd1);
    chk("spurious_ignored", 32'(out_valid), 32'd0);
    repeat (3) @(negedge clk);
    #1;
    chk("proto_err_sticky", 32'(proto_err), 32'd1);
    rst = 1'b0;
    #1;
    chk("proto_err_cleared", 32'(proto_err), 32'd0);
    chk("reset_req_low", 32'(imem_req), 32'd0);
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
